// File: rtl/seq_mult_add_pkg.sv
// seq_mult_add_pkg: shared types and constants for the sequential multiply-add unit.
//   state_e      - controller states (idle, shift-add run, final add, done pulse)
//   DefaultWidth - default operand width in bits
//   CountWidth   - step counter width for DefaultWidth, wide enough to hold the value WIDTH
package seq_mult_add_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned CountWidth   = $clog2(DefaultWidth + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StAdd,
        StDone
    } state_e;

endpackage

// File: rtl/seq_mult_add_if.sv
// seq_mult_add_if: start/done handshake and operand/result bus of seq_mult_add.
//   start        - request a new operation (controller -> unit)
//   multiplicand - operand M
//   multiplier   - operand Q
//   addend       - value added to M*Q
//   busy         - operation in progress (unit -> controller)
//   done         - one-cycle result-valid pulse
//   product      - 2*WIDTH-bit result, held until the next accepted start
// Modports: master = ALU controller, slave = seq_mult_add.
interface seq_mult_add_if
    import seq_mult_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     addend;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier, addend,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier, addend,
        output busy, done, product
    );

endinterface

// File: rtl/mult_add_stage.sv
// mult_add_stage: combinational unsigned adder with carry-out.
//   a_i, b_i - Width-bit addends
//   sum_o    - Width-bit sum
//   carry_o  - carry out of the MSB
module mult_add_stage #(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] sum_o,
    output logic             carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_mult_add.sv
// seq_mult_add: sequential unsigned multiply-accumulate, product = M * Q + addend.
// Shift-add over WIDTH cycles followed by one cycle adding the addend; done pulses
// WIDTH+1 cycles after the accepted start. All outputs are registered.
//   clk - rising-edge clock
//   rst - synchronous active-high reset (wins over start)
//   bus - seq_mult_add_if slave: start/operands in, busy/done/product out
module seq_mult_add
    import seq_mult_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst,
    seq_mult_add_if.slave      bus
);

    localparam int unsigned      CntW     = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0]  LastStep = CntW'(WIDTH - 1);

    state_e               state_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     addend_q;
    logic [WIDTH-1:0]     p_hi_q;
    logic [WIDTH-1:0]     p_lo_q;
    logic [CntW-1:0]      count_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     step_b;
    logic [WIDTH-1:0]     step_sum;
    logic                 step_carry;
    logic [2*WIDTH-1:0]   add_b;
    logic [2*WIDTH-1:0]   add_sum;
    logic                 add_carry_unused;  // result never exceeds 2*WIDTH bits

    // Conditional add of M into the upper half when the current multiplier bit is set.
    assign step_b = p_lo_q[0] ? m_q : '0;

    mult_add_stage #(
        .Width (WIDTH)
    ) u_step (
        .a_i     (p_hi_q),
        .b_i     (step_b),
        .sum_o   (step_sum),
        .carry_o (step_carry)
    );

    assign add_b = {{WIDTH{1'b0}}, addend_q};

    mult_add_stage #(
        .Width (2 * WIDTH)
    ) u_acc (
        .a_i     ({p_hi_q, p_lo_q}),
        .b_i     (add_b),
        .sum_o   (add_sum),
        .carry_o (add_carry_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            m_q       <= '0;
            addend_q  <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        m_q      <= bus.multiplicand;
                        addend_q <= bus.addend;
                        p_hi_q   <= '0;
                        p_lo_q   <= bus.multiplier;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    // Shift {carry, P_hi, P_lo} right by one after the conditional add.
                    p_hi_q  <= {step_carry, step_sum[WIDTH-1:1]};
                    p_lo_q  <= {step_sum[0], p_lo_q[WIDTH-1:1]};
                    count_q <= count_q + CntW'(1);
                    if (count_q == LastStep) begin
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    product_q <= add_sum;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_add.sv
// tb_seq_mult_add: scoreboard bench for seq_mult_add. The driver pushes the expected
// product and the start cycle; a monitor pops and compares on every done pulse.
module tb_seq_mult_add;
    import seq_mult_add_pkg::*;

    localparam int W   = 16;
    localparam int Lat = W + 1;

    typedef struct {
        logic [31:0] prod;
        int          c0;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_mult_add_if #(.WIDTH(W)) bus ();

    seq_mult_add #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   cyc = 0;
    always @(posedge clk) cyc++;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   dones       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done at cycle %0d: got done=1, expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, " product"}, bus.product, e.prod);
                check({e.name, " latency"}, 32'(cyc - e.c0), 32'(Lat));
                check({e.name, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    // Drive start for one edge; caller is just after a negedge in an IDLE cycle.
    task automatic issue(input string name, input logic [15:0] m, input logic [15:0] q,
                         input logic [15:0] a, input logic [31:0] expv, input bit push);
        exp_t e;
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.addend       = a;
        @(posedge clk);
        #1;
        if (push) begin
            e.prod = expv;
            e.c0   = cyc;
            e.name = name;
            sb.push_back(e);
        end
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, then step into the first IDLE cycle after it.
    task automatic wait_done(input string name);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no done, expected done within 40 cycles", name);
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        logic [15:0] dv;
        logic [15:0] qv;
        logic [15:0] rv;
        logic [31:0] dividend;

        // Reset with start held high and random operands.
        bus.start        = 1'b1;
        bus.multiplicand = 16'($urandom);
        bus.multiplier   = 16'($urandom);
        bus.addend       = 16'($urandom);
        rst              = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset product", bus.product, 32'h0000_0000);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset busy", {31'd0, bus.busy}, 32'd0);
        check("post_reset product", bus.product, 32'h0000_0000);

        // Nominal and extremes.
        issue("nominal", 16'h1234, 16'h0056, 16'h0012, 32'h0006_1D8A, 1'b1);
        wait_done("nominal");
        issue("all_ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 1'b1);
        wait_done("all_ones");
        issue("zero_m", 16'h0000, 16'hABCD, 16'h0007, 32'h0000_0007, 1'b1);
        wait_done("zero_m");
        check("product_hold", bus.product, 32'h0000_0007);

        // Busy isolation: second start and operand changes after acceptance are ignored.
        d0 = dones;
        issue("isolation", 16'h00FF, 16'h0101, 16'h0001, 32'h0001_0000, 1'b1);
        bus.multiplicand = 16'hDEAD;
        bus.multiplier   = 16'hBEEF;
        bus.addend       = 16'h5555;
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("isolation");
        repeat (25) @(negedge clk);
        check("isolation done_count", 32'(dones - d0), 32'd1);

        // Reset in the middle of RUN aborts with no done.
        d0 = dones;
        issue("aborted", 16'h1111, 16'h2222, 16'h3333, 32'h0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort product", bus.product, 32'h0000_0000);
        check("abort state", 32'(dut.state_q), 32'(StIdle));
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort done_count", 32'(dones - d0), 32'd0);
        issue("after_abort", 16'd3, 16'd5, 16'd1, 32'h0000_0010, 1'b1);
        wait_done("after_abort");

        // Divider round trip, back-to-back on the first IDLE cycle after each done.
        for (int i = 0; i < 1000; i++) begin
            dv       = 16'($urandom_range(65535, 1));
            qv       = 16'($urandom);
            rv       = 16'($urandom_range(int'(dv) - 1, 0));
            dividend = 32'(qv) * 32'(dv) + 32'(rv);
            issue("round_trip", dv, qv, rv, dividend, 1'b1);
            wait_done("round_trip");
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_mult_add.md
# seq_mult_add

Sequential unsigned multiply-accumulate unit for the 16-bit ALU, computing product = multiplicand × multiplier + addend over WIDTH+1 clock cycles. It is the inverse path of the ALU's divider: quotient, divisor and remainder go in, and the dividend comes out. It sits beside the divider in the ALU datapath and uses a one-shot start/done handshake driven by the ALU controller.

## Interface
- WIDTH, 16, operand width in bits; product width is 2×WIDTH.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- multiplicand  input  WIDTH  unsigned operand M; latched on an accepted start.
- multiplier  input  WIDTH  unsigned operand Q; latched on an accepted start.
- addend  input  WIDTH  unsigned value added to M×Q; latched on an accepted start.
- busy  output  1  high in RUN and ADD.
- done  output  1  one-cycle pulse; product is valid in this cycle.
- product  output  2×WIDTH  result; holds until the next accepted start or reset.

## Operation
- States:
  - IDLE: start=1 latches M, Q and addend, clears P_hi and carry, sets P_lo=Q and count=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: one shift-add step per cycle.
    - If P_lo[0]=1, {carry,P_hi} = P_hi + M; otherwise {carry,P_hi} = {0,P_hi}.
    - Then {carry,P_hi,P_lo} is shifted right by 1 and count increments.
    - After WIDTH steps the block goes to ADD.
  - ADD: product = {P_hi,P_lo} + zero-extended addend, then go to DONE.
  - DONE: done=1, then return to IDLE unconditionally.
- Arithmetic:
  - Unsigned only; no overflow is possible. The maximum result is (2^W−1)^2 + (2^W−1) = 2^2W − 2^W.
  - The internal accumulator is W+1 bits (carry plus P_hi).
- start:
  - Ignored in RUN, ADD and DONE. No queueing, no error flag.
  - Operand inputs may change freely after acceptance; the latched copies are used.
- Reset:
  - Values: state=IDLE, busy=0, done=0, product=0, count=0, internal registers 0.
  - rst takes priority over start in the same cycle.
  - rst during RUN or ADD aborts the operation; no done pulse is produced.

## Timing
- Start accepted at clock edge E0.
- RUN steps occur at edges E1..E_W. The ADD update occurs at edge E_W+1.
- done=1 and product valid in the cycle after edge E_W+1, i.e. W+1 cycles after E0 (17 cycles for W=16).
- busy rises in the cycle after E0 and falls in the same cycle that done rises.
- The earliest next accepted start is the cycle after done, with state back in IDLE. Throughput is one operation per W+3 cycles.
- Latency is fixed and independent of the operand values, including zero operands.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package seq_mult_add_pkg holds:
  - the state enum (IDLE, RUN, ADD, DONE),
  - the default WIDTH,
  - the counter width localparam $clog2(WIDTH+1).
- Sub-module mult_add_stage: a combinational WIDTH-bit adder with carry-out. It is instantiated twice:
  - once for the RUN-step conditional add,
  - once, in a 2W-wide configuration, for the ADD state.
- All registers sit in a single clocked process in seq_mult_add.

## Test plan
- Reset: hold rst 2 cycles with start=1 and random operands -> busy=0, done=0, product=0x00000000. No operation is started.
- Nominal: M=0x1234, Q=0x0056, addend=0x0012 -> done exactly 17 cycles after the start edge, product=0x00061D8A, busy low on the done cycle.
- Extremes: M=Q=addend=0xFFFF -> product=0xFFFF0000. Also M=0x0000, Q=0xABCD, addend=0x0007 -> product=0x00000007 with the same 17-cycle latency.
- Busy/operand isolation:
  - Pulse start again 5 cycles into an operation with different operands -> ignored.
  - Change the operand inputs after acceptance -> result reflects only the first latched operands.
  - Exactly one done pulse.
- Reset mid-operation: assert rst at cycle 8 of RUN -> next cycle IDLE, product=0, no done. A following start with M=3, Q=5, addend=1 -> product=0x00000010.
- Divider round trip: random 1000 pairs where dividend = q×d + r with r<d -> product equals the dividend. Also back-to-back starts issued on the first IDLE cycle after each done.
